conv_job_scheduler: RTL and testbench

Command-queue sequencer in front of the conv engine. The host pushes convolution job descriptors into an internal FIFO. The scheduler pops one job at a time, validates it, and derives result_width/result_height by iterative division. It then drives the engine's configuration pins, pulses start, watches done with a timeout, and returns a tagged completion record to the host over a ready/valid response port.

---
 rtl/conv_job_scheduler.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_conv_job_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler: job sequencer in front of the convolution engine.
//
// The host pushes descriptors into a DEPTH-entry FIFO. One job at a time is
// popped, validated, and its output size is found by repeated subtraction.
// The engine is then configured, started and watched with a timeout, and a
// tagged completion record is returned to the host.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   cmd_valid/ready/desc host descriptor push port
//                        desc = {tag, sy, sx, kh, kw, dh[7:0], dw[7:0]}, dw at LSBs
//   eng_*                engine configuration, start pulse, done input, engine reset
//   rsp_valid/ready      completion record handshake (rsp_tag, rsp_status)
//   busy                 scheduler not idle
//   queue_level          FIFO occupancy
module conv_job_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4,
  parameter int unsigned KMAX  = 5,
  parameter int unsigned TMO_W = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [32+TAGW-1:0]       cmd_desc,
  output logic [7:0]               eng_data_width,
  output logic [7:0]               eng_data_height,
  output logic [7:0]               eng_result_width,
  output logic [7:0]               eng_result_height,
  output logic [3:0]               eng_stride_x,
  output logic [3:0]               eng_stride_y,
  output logic [3:0]               eng_kernel_width,
  output logic [3:0]               eng_kernel_height,
  output logic                     eng_start,
  input  logic                     eng_done,
  output logic                     eng_rst_n,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [TAGW-1:0]          rsp_tag,
  output logic [1:0]               rsp_status,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_level
);

  localparam int unsigned DescW = 32 + TAGW;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusBadCfg  = 2'b01;
  localparam logic [1:0] StatusTimeout = 2'b10;

  // StTmo holds the engine in reset for two cycles after a timeout.
  typedef enum logic [2:0] {
    StIdle, StLoad, StCheck, StDiv, StStart, StRun, StTmo, StResp
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Descriptor FIFO
  // ---------------------------------------------------------------------------
  logic [DescW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             full, empty, push, pop;

  assign full  = (level_q == LvlW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = cmd_valid && !full;
  // LOAD is only entered with a non-empty FIFO, so the pop can never underflow.
  assign pop   = (state_q == StLoad);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= cmd_desc;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      level_q <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Job datapath
  // ---------------------------------------------------------------------------
  logic [DescW-1:0] desc_q, desc_d;
  logic [7:0]       remx_q, remx_d, remy_q, remy_d;
  logic [7:0]       qx_q, qx_d, qy_q, qy_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             hold_q, hold_d;
  logic [31:0]      cfg_q, cfg_d;
  logic [7:0]       res_w_q, res_w_d, res_h_q, res_h_d;
  logic [TAGW-1:0]  rsp_tag_q, rsp_tag_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic             eng_rst_n_q;

  logic [7:0]      d_dw, d_dh;
  logic [3:0]      d_kw, d_kh, d_sx, d_sy;
  logic [TAGW-1:0] d_tag;
  logic            bad_cfg, x_step, y_step;

  assign d_dw  = desc_q[7:0];
  assign d_dh  = desc_q[15:8];
  assign d_kw  = desc_q[19:16];
  assign d_kh  = desc_q[23:20];
  assign d_sx  = desc_q[27:24];
  assign d_sy  = desc_q[31:28];
  assign d_tag = desc_q[DescW-1:32];

  assign bad_cfg = (d_sx == 4'd0) || (d_sy == 4'd0) ||
                   (d_kw == 4'd0) || (d_kh == 4'd0) ||
                   ({28'd0, d_kw} > KMAX) || ({28'd0, d_kh} > KMAX) ||
                   ({4'd0, d_kw} > d_dw) || ({4'd0, d_kh} > d_dh);

  assign x_step = (remx_q >= {4'd0, d_sx});
  assign y_step = (remy_q >= {4'd0, d_sy});

  always_comb begin
    state_d      = state_q;
    desc_d       = desc_q;
    remx_d       = remx_q;
    remy_d       = remy_q;
    qx_d         = qx_q;
    qy_d         = qy_q;
    tmo_cnt_d    = tmo_cnt_q;
    hold_d       = hold_q;
    cfg_d        = cfg_q;
    res_w_d      = res_w_q;
    res_h_d      = res_h_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      StIdle: begin
        if (!empty) state_d = StLoad;
      end
      StLoad: begin
        desc_d  = mem_q[rd_ptr_q];
        state_d = StCheck;
      end
      StCheck: begin
        if (bad_cfg) begin
          rsp_tag_d    = d_tag;
          rsp_status_d = StatusBadCfg;
          state_d      = StResp;
        end else begin
          // Kernel <= data is established above, so these cannot underflow.
          remx_d  = d_dw - {4'd0, d_kw};
          remy_d  = d_dh - {4'd0, d_kh};
          qx_d    = '0;
          qy_d    = '0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        if (!x_step && !y_step) begin
          cfg_d   = desc_q[31:0];
          res_w_d = qx_q;
          res_h_d = qy_q;
          state_d = StStart;
        end else begin
          if (x_step) begin
            remx_d = remx_q - {4'd0, d_sx};
            qx_d   = qx_q + 8'd1;
          end
          if (y_step) begin
            remy_d = remy_q - {4'd0, d_sy};
            qy_d   = qy_q + 8'd1;
          end
        end
      end
      StStart: begin
        tmo_cnt_d = '0;
        state_d   = StRun;
      end
      StRun: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // Done takes priority over a timeout expiring in the same cycle.
        if (eng_done) begin
          rsp_tag_d    = d_tag;
          rsp_status_d = StatusOk;
          state_d      = StResp;
        end else if (&tmo_cnt_d) begin
          hold_d  = 1'b0;
          state_d = StTmo;
        end
      end
      StTmo: begin
        if (hold_q) begin
          rsp_tag_d    = d_tag;
          rsp_status_d = StatusTimeout;
          state_d      = StResp;
        end else begin
          hold_d = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      desc_q       <= '0;
      remx_q       <= '0;
      remy_q       <= '0;
      qx_q         <= '0;
      qy_q         <= '0;
      tmo_cnt_q    <= '0;
      hold_q       <= 1'b0;
      cfg_q        <= '0;
      res_w_q      <= '0;
      res_h_q      <= '0;
      rsp_tag_q    <= '0;
      rsp_status_q <= '0;
      eng_rst_n_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      desc_q       <= desc_d;
      remx_q       <= remx_d;
      remy_q       <= remy_d;
      qx_q         <= qx_d;
      qy_q         <= qy_d;
      tmo_cnt_q    <= tmo_cnt_d;
      hold_q       <= hold_d;
      cfg_q        <= cfg_d;
      res_w_q      <= res_w_d;
      res_h_q      <= res_h_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_status_q <= rsp_status_d;
      // Registered so the engine reset is glitch-free and low exactly in StTmo.
      eng_rst_n_q  <= (state_d != StTmo);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready         = !full;
  assign queue_level       = level_q;
  assign busy              = (state_q != StIdle);
  assign eng_start         = (state_q == StStart);
  assign eng_rst_n         = eng_rst_n_q;
  assign rsp_valid         = (state_q == StResp);
  assign rsp_tag           = rsp_tag_q;
  assign rsp_status        = rsp_status_q;
  assign eng_data_width    = cfg_q[7:0];
  assign eng_data_height   = cfg_q[15:8];
  assign eng_kernel_width  = cfg_q[19:16];
  assign eng_kernel_height = cfg_q[23:20];
  assign eng_stride_x      = cfg_q[27:24];
  assign eng_stride_y      = cfg_q[31:28];
  assign eng_result_width  = res_w_q;
  assign eng_result_height = res_h_q;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Testbench for conv_job_scheduler: directed scenarios plus a randomized job
// stream, checked against a transaction-level model (expected responses in
// push order, expected engine configuration per started job).
module tb_conv_job_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 4;
  localparam int unsigned KMAX  = 5;
  localparam int unsigned TMO_W = 5;
  localparam int TmoCyc   = (1 << TMO_W) - 1;
  localparam int WaitMax  = 2000;
  localparam int DrainMax = 20000;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [35:0] cmd_desc;
  logic [7:0]  eng_data_width, eng_data_height, eng_result_width, eng_result_height;
  logic [3:0]  eng_stride_x, eng_stride_y, eng_kernel_width, eng_kernel_height;
  logic        eng_start, eng_done, eng_rst_n;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_tag;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [2:0]  queue_level;

  logic eng_done_e, stray_done, rand_mode, rr_rand, rr_dir;
  assign eng_done  = eng_done_e | stray_done;
  assign rsp_ready = rand_mode ? rr_rand : rr_dir;

  conv_job_scheduler #(
    .DEPTH(DEPTH), .TAGW(TAGW), .KMAX(KMAX), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_desc(cmd_desc),
    .eng_data_width(eng_data_width), .eng_data_height(eng_data_height),
    .eng_result_width(eng_result_width), .eng_result_height(eng_result_height),
    .eng_stride_x(eng_stride_x), .eng_stride_y(eng_stride_y),
    .eng_kernel_width(eng_kernel_width), .eng_kernel_height(eng_kernel_height),
    .eng_start(eng_start), .eng_done(eng_done), .eng_rst_n(eng_rst_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_status(rsp_status), .busy(busy), .queue_level(queue_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [3:0] tag; logic [1:0] status; } rsp_t;
  typedef struct { logic [35:0] desc; int lat; } job_t;

  rsp_t exp_rsp[$];
  job_t eng_q[$];
  int   checks = 0, errors = 0;
  int   eng_starts = 0, exp_starts = 0, rsp_count = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [35:0] mk_desc(input logic [3:0] tag, input logic [3:0] sy,
                                          input logic [3:0] sx, input logic [3:0] kh,
                                          input logic [3:0] kw, input logic [7:0] dh,
                                          input logic [7:0] dw);
    return {tag, sy, sx, kh, kw, dh, dw};
  endfunction

  function automatic bit is_bad(input logic [35:0] d);
    int dw, dh, kw, kh, sx, sy;
    dw = int'(d[7:0]);   dh = int'(d[15:8]);
    kw = int'(d[19:16]); kh = int'(d[23:20]);
    sx = int'(d[27:24]); sy = int'(d[31:28]);
    return sx == 0 || sy == 0 || kw == 0 || kh == 0 || kw > int'(KMAX) ||
           kh > int'(KMAX) || kw > dw || kh > dh;
  endfunction

  function automatic int res_w(input logic [35:0] d);
    return (int'(d[7:0]) - int'(d[19:16])) / int'(d[27:24]);
  endfunction

  function automatic int res_h(input logic [35:0] d);
    return (int'(d[15:8]) - int'(d[23:20])) / int'(d[31:28]);
  endfunction

  // Engine answers lat cycles after start; lat==0 means it never answers.
  function automatic logic [1:0] exp_status(input logic [35:0] d, input int lat);
    if (is_bad(d)) return 2'b01;
    if (lat == 0 || lat > TmoCyc) return 2'b10;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [35:0] d, input int lat);
    int n;
    rsp_t r;
    job_t j;
    cmd_valid = 1'b1;
    cmd_desc  = d;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < WaitMax) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", cmd_ready, 1);
    @(posedge clk);
    r.tag    = d[35:32];
    r.status = exp_status(d, lat);
    exp_rsp.push_back(r);
    if (!is_bad(d)) begin
      j.desc = d;
      j.lat  = lat;
      eng_q.push_back(j);
      exp_starts++;
    end
    #1 cmd_valid = 1'b0;
  endtask

  // sel: 0 = eng_start high, 1 = rsp_valid high, 2 = eng_rst_n low
  task automatic wait_for(input int sel, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    do begin
      tick();
      n++;
      case (sel)
        0:       hit = (eng_start === 1'b1);
        1:       hit = (rsp_valid === 1'b1);
        default: hit = (eng_rst_n === 1'b0);
      endcase
    end while (!hit && n < WaitMax);
    chk("wait_bound", hit, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_rsp.size() != 0 && n < DrainMax) begin
      tick();
      n++;
    end
    chk("drain_all", exp_rsp.size(), 0);
    tick();
    tick();
  endtask

  // ---------------- engine model ----------------
  initial begin
    bit   armed;
    int   remain;
    job_t j;
    armed      = 1'b0;
    remain     = 0;
    eng_done_e = 1'b0;
    forever begin
      tick();
      eng_done_e = 1'b0;
      if (rst_n !== 1'b1) armed = 1'b0;
      if (armed) begin
        remain--;
        if (remain == 0) begin
          eng_done_e = 1'b1;
          armed      = 1'b0;
        end
      end
      if (eng_start === 1'b1) begin
        eng_starts++;
        chk("start_has_job", eng_q.size() != 0, 1);
        if (eng_q.size() != 0) begin
          j = eng_q.pop_front();
          chk("cfg_dw", eng_data_width, j.desc[7:0]);
          chk("cfg_dh", eng_data_height, j.desc[15:8]);
          chk("cfg_kw", eng_kernel_width, j.desc[19:16]);
          chk("cfg_kh", eng_kernel_height, j.desc[23:20]);
          chk("cfg_sx", eng_stride_x, j.desc[27:24]);
          chk("cfg_sy", eng_stride_y, j.desc[31:28]);
          chk("cfg_rw", eng_result_width, 64'(res_w(j.desc)));
          chk("cfg_rh", eng_result_height, 64'(res_h(j.desc)));
          if (j.lat > 0) begin
            armed  = 1'b1;
            remain = j.lat;
          end
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    rsp_t r;
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      rsp_count++;
      chk("rsp_expected", exp_rsp.size() != 0, 1);
      if (exp_rsp.size() != 0) begin
        r = exp_rsp.pop_front();
        chk("rsp_tag", rsp_tag, r.tag);
        chk("rsp_status", rsp_status, r.status);
      end
    end
  end

  initial begin
    rr_rand = 1'b0;
    forever begin
      tick();
      rr_rand = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, base, low_cnt;
    rsp_t r;
    logic [3:0] t, kw, kh, sx, sy;
    logic [7:0] dw, dh;
    logic [35:0] d;
    int lat;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_desc = '0;
    stray_done = 1'b0; rand_mode = 1'b0; rr_dir = 1'b1;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_eng_rst_n", eng_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", queue_level, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_cfg", {eng_data_width, eng_result_width, eng_stride_x, eng_kernel_width}, 0);
    rst_n = 1'b1;
    tick();
    chk("eng_rst_n_rise", eng_rst_n, 1);
    tick();

    // 1: nominal job, DIV length and result size
    d = mk_desc(4'd5, 4'd2, 4'd1, 4'd3, 4'd3, 8'd8, 8'd8);
    push(d, 20);
    wait_for(0, n);
    chk("t1_start_latency", n, 64'(3 + ((res_w(d) > res_h(d)) ? res_w(d) : res_h(d)) + 1));
    chk("t1_result_w", eng_result_width, 5);
    chk("t1_result_h", eng_result_height, 2);
    wait_for(1, n);
    chk("t1_done_to_rsp", n, 21);
    drain();
    chk("t1_one_start", eng_starts, 1);

    // 2: kernel wider than KMAX is rejected without starting the engine
    push(mk_desc(4'd3, 4'd1, 4'd1, 4'd1, 4'd6, 8'd8, 8'd8), 5);
    wait_for(1, n);
    chk("t2_bad_latency", n, 3);
    drain();
    chk("t2_no_start", eng_starts, 1);

    // 5: response stalls, stray done pulses ignored, next job stays queued
    rr_dir = 1'b0;
    push(mk_desc(4'd9, 4'd1, 4'd2, 4'd2, 4'd2, 8'd10, 8'd12), 5);
    push(mk_desc(4'd10, 4'd1, 4'd1, 4'd1, 4'd1, 8'd4, 8'd4), 3);
    wait_for(1, n);
    base = eng_starts;
    r = exp_rsp[0];
    for (int i = 0; i < 10; i++) begin
      stray_done = 1'(i % 2);
      tick();
      chk("t5_valid_held", rsp_valid, 1);
      chk("t5_tag_held", rsp_tag, r.tag);
      chk("t5_status_held", rsp_status, r.status);
      chk("t5_queue_level", queue_level, 1);
    end
    stray_done = 1'b0;
    chk("t5_no_new_start", eng_starts, base);
    rr_dir = 1'b1;
    drain();

    // 3: fill the FIFO while a job runs; in-order completion
    base = rsp_count;
    push(mk_desc(4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 8'd6, 8'd6), 25);
    wait_for(0, n);
    for (int i = 0; i < int'(DEPTH); i++) begin
      push(mk_desc(4'(2 + i), 4'd1, 4'(1 + i % 3), 4'd3, 4'(1 + i), 8'd9, 8'd7),
           2 + i);
      chk("t3_level", queue_level, 64'(i + 1));
    end
    chk("t3_full_ready", cmd_ready, 0);
    drain();
    chk("t3_rsp_count", rsp_count - base, 64'(DEPTH + 1));

    // 4: engine never answers, timeout with engine reset pulse
    push(mk_desc(4'd7, 4'd1, 4'd1, 4'd2, 4'd2, 8'd5, 8'd5), 0);
    push(mk_desc(4'd8, 4'd3, 4'd2, 4'd4, 4'd5, 8'd30, 8'd20), 4);
    wait_for(0, n);
    wait_for(2, n);
    chk("t4_tmo_latency", n, 64'(TmoCyc + 1));
    low_cnt = 1;
    n = 0;
    do begin
      tick();
      n++;
      if (eng_rst_n === 1'b0) low_cnt++;
    end while (eng_rst_n === 1'b0 && n < 10);
    chk("t4_rst_low_cycles", low_cnt, 2);
    chk("t4_rsp_after_rst", rsp_valid, 1);
    drain();

    // random job stream with random response back-pressure
    rand_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      t  = 4'($urandom);
      dw = 8'($urandom_range(1, 60));
      dh = 8'($urandom_range(1, 60));
      kw = 4'($urandom_range(1, 5));
      kh = 4'($urandom_range(1, 5));
      sx = 4'($urandom_range(1, 4));
      sy = 4'($urandom_range(1, 4));
      case ($urandom_range(0, 7))
        0: kw = 4'($urandom_range(6, 15));
        1: sy = 4'd0;
        2: kh = 4'd0;
        3: dw = 8'($urandom_range(0, 2));
        default: ;
      endcase
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TmoCyc + 3);
      push(mk_desc(t, sy, sx, kh, kw, dh, dw), lat);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    rand_mode = 1'b0;
    rr_dir    = 1'b1;

    // 6: reset during DIV drops everything
    push(mk_desc(4'd11, 4'd1, 4'd1, 4'd1, 4'd1, 8'd8, 8'd200), 3);
    push(mk_desc(4'd12, 4'd1, 4'd1, 4'd1, 4'd1, 8'd4, 8'd4), 3);
    push(mk_desc(4'd13, 4'd1, 4'd1, 4'd1, 4'd1, 8'd4, 8'd4), 3);
    tick(); tick();
    chk("t6_busy_before", busy, 1);
    chk("t6_level_before", queue_level, 2);
    rst_n = 1'b0;
    #1;
    exp_starts = exp_starts - eng_q.size();
    eng_q.delete();
    exp_rsp.delete();
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_level", queue_level, 0);
    chk("t6_busy", busy, 0);
    chk("t6_eng_start", eng_start, 0);
    chk("t6_eng_rst_n", eng_rst_n, 0);
    chk("t6_rsp", {rsp_valid, rsp_tag, rsp_status}, 0);
    chk("t6_cfg_a", {eng_data_width, eng_data_height, eng_result_width, eng_result_height}, 0);
    chk("t6_cfg_b", {eng_stride_x, eng_stride_y, eng_kernel_width, eng_kernel_height}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t6_eng_rst_n_rise", eng_rst_n, 1);
    base = rsp_count;
    repeat (300) tick();
    chk("t6_no_response", rsp_count, base);
    chk("t6_idle_after", busy, 0);
    chk("t6_level_after", queue_level, 0);

    chk("final_starts", eng_starts, exp_starts);
    chk("final_model_empty", exp_rsp.size() + eng_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
